// File: rtl/tile_blitter_if.sv
// Bus bundle between the tile blitter and its host, ROM and VGA framebuffer port.
interface tile_blitter_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned RGB_W   = 24
);
  logic               start;
  logic [ADDR_W-1:0]  tile_base;
  logic [COORD_W-1:0] x_origin;
  logic [COORD_W-1:0] y_origin;
  logic               hflip;
  logic               vflip;
  logic               transp_en;
  logic [RGB_W-1:0]   rom_data;
  logic [ADDR_W-1:0]  rom_addr;
  logic               vga_draw_enable;
  logic [COORD_W-1:0] vga_x;
  logic [COORD_W-1:0] vga_y;
  logic [RGB_W-1:0]   vga_rgb;
  logic               busy;
  logic               done;

  modport slave (
    input  start, tile_base, x_origin, y_origin, hflip, vflip, transp_en, rom_data,
    output rom_addr, vga_draw_enable, vga_x, vga_y, vga_rgb, busy, done
  );

  modport master (
    output start, tile_base, x_origin, y_origin, hflip, vflip, transp_en, rom_data,
    input  rom_addr, vga_draw_enable, vga_x, vga_y, vga_rgb, busy, done
  );
endinterface

// File: rtl/tile_blitter.sv
// Copies one TILE_W x TILE_H tile from ROM to the VGA pixel port, one pixel per cycle,
// with optional flips, screen clipping and colour-key transparency.
module tile_blitter #(
  parameter int unsigned      TILE_W   = 8,
  parameter int unsigned      TILE_H   = 8,
  parameter int unsigned      ADDR_W   = 16,
  parameter int unsigned      COORD_W  = 8,
  parameter int unsigned      RGB_W    = 24,
  parameter int unsigned      SCREEN_W = 160,
  parameter int unsigned      SCREEN_H = 120,
  parameter logic [RGB_W-1:0] KEY_RGB  = RGB_W'(24'hFF00FF)
) (
  input logic           clk,
  input logic           reset,
  tile_blitter_if.slave bus
);
  localparam int unsigned CW = $clog2(TILE_W);
  localparam int unsigned RW = $clog2(TILE_H);
  localparam int unsigned SW = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      col_q, col_d, c2_q;
  logic [RW-1:0]      row_q, row_d, r2_q;
  logic               flush_q, flush_d;
  logic               v1_q, v1_d, v2_q;
  logic [ADDR_W-1:0]  base_q, base_d, addr_q, addr_d;
  logic [COORD_W-1:0] xo_q, xo_d, yo_q, yo_d;
  logic               hf_q, hf_d, vf_q, vf_d, te_q, te_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               de_q;
  logic [COORD_W-1:0] vx_q, vy_q;
  logic [RGB_W-1:0]   rgb_q;
  logic [CW-1:0]      sc;
  logic [RW-1:0]      sr;
  logic [SW-1:0]      sum_x, sum_y;
  logic               visible, keyed;

  // Next-state, address generation and latching of the tile request.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    flush_d = flush_q;
    v1_d    = 1'b0;
    base_d  = base_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    hf_d    = hf_q;
    vf_d    = vf_q;
    te_d    = te_q;
    case (state_q)
      IDLE: if (bus.start) begin
        base_d  = bus.tile_base;
        xo_d    = bus.x_origin;
        yo_d    = bus.y_origin;
        hf_d    = bus.hflip;
        vf_d    = bus.vflip;
        te_d    = bus.transp_en;
        col_d   = '0;
        row_d   = '0;
        v1_d    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (col_q == CW'(TILE_W - 1) && row_q == RW'(TILE_H - 1)) begin
          flush_d = 1'b0;
          state_d = FLUSH;
        end else begin
          v1_d = 1'b1;
          if (col_q == CW'(TILE_W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sc     = hf_d ? CW'(TILE_W - 1) - col_d : col_d;
    sr     = vf_d ? RW'(TILE_H - 1) - row_d : row_d;
    addr_d = base_d + ADDR_W'(sr) * ADDR_W'(TILE_W) + ADDR_W'(sc);
    busy_d = (state_d == RUN) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  // Pixel slot qualification: clip at COORD_W+1 bits, then colour key.
  always_comb begin
    sum_x   = SW'(xo_q) + SW'(c2_q);
    sum_y   = SW'(yo_q) + SW'(r2_q);
    visible = (sum_x < SW'(SCREEN_W)) && (sum_y < SW'(SCREEN_H));
    keyed   = te_q && (bus.rom_data == KEY_RGB);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      flush_q <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      c2_q    <= '0;
      r2_q    <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      hf_q    <= 1'b0;
      vf_q    <= 1'b0;
      te_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      de_q    <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      flush_q <= flush_d;
      v1_q    <= v1_d;
      v2_q    <= v1_q;
      c2_q    <= col_q;
      r2_q    <= row_q;
      base_q  <= base_d;
      addr_q  <= addr_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      hf_q    <= hf_d;
      vf_q    <= vf_d;
      te_q    <= te_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      de_q    <= v2_q && visible && !keyed;
      vx_q    <= xo_q + COORD_W'(c2_q);
      vy_q    <= yo_q + COORD_W'(r2_q);
      rgb_q   <= bus.rom_data;
    end
  end

  // Shared buses are released whenever the blitter is not busy.
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.rom_addr        = busy_q ? addr_q : 'z;
  assign bus.vga_draw_enable = busy_q ? de_q   : 1'bz;
  assign bus.vga_x           = busy_q ? vx_q   : 'z;
  assign bus.vga_y           = busy_q ? vy_q   : 'z;
  assign bus.vga_rgb         = busy_q ? rgb_q  : 'z;
endmodule
